seq_bin_multiplier: RTL and testbench
=====================================

Name: seq_bin_multiplier

Overview:
- Iterative shift-add binary multiplier, parametrised in operand width.
- Supports unsigned and two's-complement signed modes, selected per operation.
- Valid/ready handshakes on both the input and the output.
- Sits beside the combinational adder/multiplier blocks. Used where area matters more than throughput; one operation is in flight at a time.

Parameters:
- WIDTH, 8, operand width in bits. Legal range 2..32. Product width is 2*WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands and mode are presented.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier.
- signed_mode  in  1  1 = operands and product are two's complement; 0 = unsigned.
- abort  in  1  synchronous cancel of the current operation.
- out_valid  out  1  product is available.
- out_ready  in  1  consumer accepts the product.
- product  out  2*WIDTH  result.
- busy  out  1  high in BUSY or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, all internal registers 0. Reset mid-operation discards the operation; no partial result is ever output.
- States: IDLE, BUSY, DONE (2-bit encoding).
- IDLE:
  - in_ready=1.
  - When in_valid&in_ready at a rising edge: latch magnitude |a|→mcand and |b|→mplier.
  - The magnitude is the two's-complement negation when signed_mode=1 and the operand MSB=1; otherwise the value as-is, zero-extended.
  - Latch neg = signed_mode & (a[MSB]^b[MSB]).
  - Clear acc (WIDTH+1 bits) and count, then go to BUSY.
- BUSY (in_ready=0, busy=1), each cycle:
  - sum = acc + (mplier[0] ? mcand : 0), WIDTH+1 bits, carry kept.
  - {acc, mplier} shifts right by one with sum as the upper part.
  - count increments.
  - On the cycle where count==WIDTH-1: register product = neg ? -raw : raw, where raw is the 2*WIDTH-bit concatenation after the final shift. Then go to DONE.
- DONE:
  - out_valid=1; product is held stable until consumed.
  - When out_ready=1 at a rising edge: out_valid falls and state returns to IDLE.
  - A new operation can be accepted from the following cycle.
- Latency: out_valid rises exactly WIDTH rising edges after the accepting edge. Throughput is one operation per WIDTH+2 cycles when out_ready is held high.
- abort:
  - In BUSY or DONE: next state IDLE, out_valid=0; product keeps its last value.
  - In IDLE: ignored. abort has priority over in_valid and over out_ready in the same cycle.
- in_valid outside IDLE is ignored, since in_ready=0. Operand and mode changes after acceptance have no effect.
- Boundary values:
  - Most-negative operand (e.g. -128 at WIDTH=8): its magnitude 2^(WIDTH-1) fits the unsigned WIDTH-bit mcand/mplier. The product is exact, e.g. -128*-128=16384.
  - Zero operand gives product 0, never a negative zero, whatever neg is.
  - The unsigned maximum (2^WIDTH-1)^2 fits 2*WIDTH bits. No overflow is possible in either mode.
- count width is clog2(WIDTH). No counter wrap occurs inside BUSY.
- product is registered and never combinational from the inputs.

Decomposition:
- Shared package mult_pkg holds:
  - the state enum (IDLE/BUSY/DONE);
  - a function for the count-width computation;
  - localparam PW = 2*WIDTH, by convention.
- One natural sub-module: cond_negate, a parametrised conditional two's-complement negator.
  - Instantiated three times: operand a, operand b, and the product.
  - It is purely combinational and unit-testable on its own.
- The shift-add datapath and FSM stay in seq_bin_multiplier.

Test Plan (WIDTH=8 unless stated):
- Unsigned basic: a=13, b=11, signed_mode=0 → product=143 after 8 edges. in_ready=0 throughout BUSY/DONE.
- Signed corners: (-128,-128) → 16384; (-1,127) → 0xFF81; (-5,0) → 0x0000; (127,-128) → 0xC080.
- Unsigned max and backpressure: a=255, b=255, out_ready=0 for 5 cycles → product=65025 held stable with out_valid=1 until out_ready=1. IDLE follows on the next edge.
- Abort and reset: abort in the 4th BUSY cycle → IDLE next edge with out_valid=0; a new op 6*7 then yields 42. rst_n pulsed low mid-BUSY asynchronously → all outputs at reset values with no clk edge needed.
- Ignored input: in_valid toggled with new operands during BUSY → original product unchanged. Back-to-back ops with out_ready=1 complete every 10 cycles.
- Parameter sweep: WIDTH=2 (3*3 unsigned=9; -2*-2 signed=4) and WIDTH=16 (random 1000 ops per mode) → compared against a reference model.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  // Counter width for a WIDTH-iteration loop; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/cond_negate.sv
// Combinational conditional two's-complement negator.
module cond_negate #(
  parameter int unsigned Width = 8
) (
  input  logic             neg_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  assign data_o = neg_i ? (~data_i + 1'b1) : data_i;

endmodule

// File: rtl/seq_bin_multiplier.sv
// Iterative shift-add multiplier, signed or unsigned per operation, one op in flight.
module seq_bin_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    product_q, product_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum;
  logic [PW-1:0]    raw, raw_signed;

  cond_negate #(.Width(WIDTH)) u_neg_a (
    .neg_i  (signed_mode & a[WIDTH-1]),
    .data_i (a),
    .data_o (a_mag)
  );

  cond_negate #(.Width(WIDTH)) u_neg_b (
    .neg_i  (signed_mode & b[WIDTH-1]),
    .data_i (b),
    .data_o (b_mag)
  );

  assign sum = acc_q + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  // {acc, mplier} after this cycle's shift, without the always-zero top bit.
  assign raw = {sum, mplier_q[WIDTH-1:1]};

  cond_negate #(.Width(PW)) u_neg_p (
    .neg_i  (neg_q),
    .data_i (raw),
    .data_o (raw_signed)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    count_d   = count_q;
    neg_d     = neg_q;
    product_d = product_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          acc_d    = {1'b0, sum[WIDTH:1]};
          mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
          count_d  = count_q + 1'b1;
          if (count_q == CW'(WIDTH - 1)) begin
            product_d = raw_signed;
            state_d   = StDone;
          end
        end
      end
      StDone: begin
        if (abort || out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign product   = product_q;

endmodule

// File: tb/tb_seq_bin_multiplier.sv
// Scoreboard bench for seq_bin_multiplier at WIDTH 2, 8 and 16.
module tb_seq_bin_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          sel = 8;
  logic        iv = 1'b0, ordy = 1'b0, abrt = 1'b0, sm = 1'b0;
  logic [15:0] a_g = '0, b_g = '0;

  logic        ir2, ov2, bz2;
  logic [3:0]  p2;
  logic        ir8, ov8, bz8;
  logic [15:0] p8;
  logic        ir16, ov16, bz16;
  logic [31:0] p16;

  logic        cur_ir, cur_ov, cur_bz;
  logic [31:0] cur_p;

  always_comb begin
    cur_ir = ir8;
    cur_ov = ov8;
    cur_bz = bz8;
    cur_p  = {16'h0, p8};
    case (sel)
      2: begin
        cur_ir = ir2; cur_ov = ov2; cur_bz = bz2; cur_p = {28'h0, p2};
      end
      16: begin
        cur_ir = ir16; cur_ov = ov16; cur_bz = bz16; cur_p = p16;
      end
      default: ;
    endcase
  end

  seq_bin_multiplier #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2), .in_ready(ir2),
    .a(a_g[1:0]), .b(b_g[1:0]), .signed_mode(sm), .abort(abrt && sel == 2),
    .out_valid(ov2), .out_ready(ordy && sel == 2), .product(p2), .busy(bz2)
  );

  seq_bin_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 8), .in_ready(ir8),
    .a(a_g[7:0]), .b(b_g[7:0]), .signed_mode(sm), .abort(abrt && sel == 8),
    .out_valid(ov8), .out_ready(ordy && sel == 8), .product(p8), .busy(bz8)
  );

  seq_bin_multiplier #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 16), .in_ready(ir16),
    .a(a_g), .b(b_g), .signed_mode(sm), .abort(abrt && sel == 16),
    .out_valid(ov16), .out_ready(ordy && sel == 16), .product(p16), .busy(bz16)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference product: interpret operands as integers, multiply, wrap to 2*w bits.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] x, input logic [15:0] y,
                                          input logic s);
    longint m, xv, yv, p;
    m  = (longint'(1) << w) - 1;
    xv = longint'(x) & m;
    yv = longint'(y) & m;
    if (s && x[w-1]) xv = xv - (longint'(1) << w);
    if (s && y[w-1]) yv = yv - (longint'(1) << w);
    p = xv * yv;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s, input int hold,
                        input bit full, input bit poke);
    int          n;
    bit          ir_seen, unstable;
    logic [31:0] held;
    n = 0;
    while (!cur_ir && n < 50) begin step(); n++; end
    if (!cur_ir) check_eq("accept_timeout", cur_ir, 1);
    a_g = x; b_g = y; sm = s; iv = 1'b1;
    step();
    iv = 1'b0;
    exp_q.push_back(ref_mul(sel, x, y, s));
    n = 0;
    ir_seen = 0;
    while (!cur_ov && n < 100) begin
      if (cur_ir) ir_seen = 1;
      if (poke) begin
        iv  = n[0];
        a_g = 16'($urandom);
        b_g = 16'($urandom);
        sm  = ~sm;
      end
      step();
      n++;
    end
    iv = 1'b0;
    if (full) begin
      check_eq("latency", n, sel);
      check_eq("in_ready_busy_done", ir_seen | cur_ir, 0);
      check_eq("busy_in_done", cur_bz, 1);
    end else if (!cur_ov) begin
      check_eq("done_timeout", cur_ov, 1);
    end
    held = cur_p;
    unstable = 0;
    ordy = 1'b0;
    repeat (hold) begin
      step();
      if (!cur_ov || cur_p !== held) unstable = 1;
    end
    if (hold > 0) check_eq("held_stable", unstable, 0);
    check_eq("product", cur_p, exp_q.pop_front());
    ordy = 1'b1;
    step();
    ordy = 1'b0;
    if (full) begin
      check_eq("out_valid_after_take", cur_ov, 0);
      check_eq("in_ready_after_take", cur_ir, 1);
    end
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, t_prev;
    bit          bad;
    logic [31:0] prev, exp_v;

    #1;
    check_eq("rst_in_ready", cur_ir, 1);
    check_eq("rst_out_valid", cur_ov, 0);
    check_eq("rst_busy", cur_bz, 0);
    check_eq("rst_product", cur_p, 0);
    #11 rst_n = 1'b1;
    step();

    sel = 8;
    run_op(16'd13, 16'd11, 1'b0, 0, 1, 0);
    run_op(16'h80, 16'h80, 1'b1, 0, 1, 0);
    run_op(16'hFF, 16'h7F, 1'b1, 0, 1, 0);
    run_op(16'hFB, 16'h00, 1'b1, 0, 1, 0);
    run_op(16'h7F, 16'h80, 1'b1, 0, 1, 0);
    run_op(16'hFF, 16'hFF, 1'b0, 5, 1, 0);
    run_op(16'd200, 16'd3, 1'b0, 0, 1, 1);

    // Abort on the 4th BUSY edge.
    prev = cur_p;
    a_g = 16'd100; b_g = 16'd100; sm = 1'b0; iv = 1'b1;
    step();
    iv = 1'b0;
    repeat (3) step();
    abrt = 1'b1;
    step();
    abrt = 1'b0;
    check_eq("abort_busy_out_valid", cur_ov, 0);
    check_eq("abort_busy_in_ready", cur_ir, 1);
    check_eq("abort_busy_busy", cur_bz, 0);
    check_eq("abort_busy_product_kept", cur_p, prev);
    bad = 0;
    repeat (10) begin step(); if (cur_ov) bad = 1; end
    check_eq("abort_no_late_result", bad, 0);
    run_op(16'd6, 16'd7, 1'b0, 0, 1, 0);

    // Abort in DONE wins over a simultaneous out_ready; product is kept.
    exp_v = ref_mul(8, 16'd9, 16'd9, 1'b0);
    a_g = 16'd9; b_g = 16'd9; sm = 1'b0; iv = 1'b1;
    step();
    iv = 1'b0;
    n = 0;
    while (!cur_ov && n < 100) begin step(); n++; end
    check_eq("abort_done_reached", cur_ov, 1);
    ordy = 1'b1; abrt = 1'b1;
    step();
    ordy = 1'b0; abrt = 1'b0;
    check_eq("abort_done_out_valid", cur_ov, 0);
    check_eq("abort_done_in_ready", cur_ir, 1);
    check_eq("abort_done_product", cur_p, exp_v);

    // Asynchronous reset mid-BUSY, checked between clock edges.
    a_g = 16'd50; b_g = 16'd60; iv = 1'b1;
    step();
    iv = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_in_ready", cur_ir, 1);
    check_eq("async_rst_out_valid", cur_ov, 0);
    check_eq("async_rst_busy", cur_bz, 0);
    check_eq("async_rst_product", cur_p, 0);
    #2 rst_n = 1'b1;
    step();

    // Back-to-back with in_valid and out_ready held high.
    ordy = 1'b1; iv = 1'b1; sm = 1'b0;
    t_prev = 0;
    for (int k = 0; k < 5; k++) begin
      a_g = 16'(k * 17 + 3);
      b_g = 16'(k * 5 + 1);
      n = 0;
      while (!cur_ir && n < 50) begin step(); n++; end
      exp_q.push_back(ref_mul(8, a_g, b_g, 1'b0));
      step();
      if (k > 0) check_eq("b2b_period", cyc - t_prev, 10);
      t_prev = cyc;
      a_g = 16'hFFFF;
      b_g = 16'hFFFF;
      n = 0;
      while (!cur_ov && n < 100) begin step(); n++; end
      check_eq("b2b_product", cur_p, exp_q.pop_front());
    end
    iv = 1'b0; ordy = 1'b0;
    step();
    step();

    sel = 2;
    run_op(16'd3, 16'd3, 1'b0, 0, 1, 0);
    run_op(16'd2, 16'd2, 1'b1, 0, 1, 0);
    run_op(16'd2, 16'd1, 1'b1, 0, 1, 0);

    sel = 16;
    run_op(16'h8000, 16'h8000, 1'b1, 0, 1, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, 0, 1, 0);
    for (int s = 0; s < 2; s++) begin
      repeat (1000) run_op(16'($urandom), 16'($urandom), s[0], 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
